// File: rtl/apb_slave_if.sv
// rtl/apb_slave_if.sv - APB bus signals between a requester and apb_slave
interface apb_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB3 completer with register-file memory and protocol checker
// Define APB_WAIT_STATE_EN to insert WAIT_CYCLES wait states in every access phase.
module apb_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  apb_slave_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
`ifdef APB_WAIT_STATE_EN
  localparam int WAITS = WAIT_CYCLES;
`else
  localparam int WAITS = 0;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic latch;
  logic complete;
  logic mem_we;
  logic unstable;

  // Access-phase bus no longer matches what was captured in setup.
  assign unstable = (bus.PADDR != addr_q) || (bus.PWRITE != write_q) ||
                    (write_q && (bus.PWDATA != wdata_q));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    cnt_d    = cnt_q;
    latch    = 1'b0;
    complete = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          state_d = SETUP;
          latch   = 1'b1;
        end
      end
      SETUP: begin
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else if (!bus.PENABLE) begin
          latch = 1'b1;
        end else if (unstable) begin
          state_d = IDLE;
        end else begin
          state_d  = ACCESS;
          cnt_d    = '0;
          complete = (WAITS == 0);
        end
      end
      ACCESS: begin
        if (pready_q) begin
          if (bus.PSEL && !bus.PENABLE) begin
            state_d = SETUP;
            latch   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!bus.PSEL || !bus.PENABLE || unstable) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(WAITS - 1)) begin
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (latch) begin
      addr_d  = bus.PADDR;
      write_d = bus.PWRITE;
      wdata_d = bus.PWDATA;
    end

    pready_d = complete;
    mem_we   = complete && write_q;
    if (complete && !write_q) begin
      prdata_d = mem_q[addr_q];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign bus.PRDATA = prdata_q;
  assign bus.PREADY = pready_q;
endmodule

// File: tb/tb_apb_slave.sv
// tb/tb_apb_slave.sv - directed and random APB traffic against a reference memory
module tb_apb_slave;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int WC = 2;
`ifdef APB_WAIT_STATE_EN
  localparam int EXP_LAT = WC + 1;
`else
  localparam int EXP_LAT = 1;
`endif

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;

  apb_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WAIT_CYCLES(WC)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  int total  = 0;
  int passed = 0;
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] exp_q [$];
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bus_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
    end
  endtask

  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat;
    logic [DW-1:0] exp;
    @(negedge PCLK);
    check("pready_low_before_setup", {31'b0, bus.PREADY}, 32'h0);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
    if (wr) ref_mem[a] = d;
    else exp_q.push_back(ref_mem[a]);
    @(negedge PCLK);
    check("pready_low_in_setup", {31'b0, bus.PREADY}, 32'h0);
    bus.PENABLE = 1'b1;
    lat = 0;
    do begin
      @(negedge PCLK);
      lat++;
    end while (bus.PREADY !== 1'b1 && lat < 20);
    check("pready_latency", lat, EXP_LAT);
    if (!wr) begin
      exp = exp_q.pop_front();
      check($sformatf("prdata_addr_%0h", a), bus.PRDATA, exp);
    end
  endtask

  task automatic hold_no_ready(input string tag, input logic [DW-1:0] prdata_exp);
    repeat (3) begin
      @(negedge PCLK);
      check({tag, "_pready"}, {31'b0, bus.PREADY}, 32'h0);
      check({tag, "_prdata"}, bus.PRDATA, prdata_exp);
    end
  endtask

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    @(negedge PCLK);
    check("reset_prdata", bus.PRDATA, 32'h0);
    check("reset_pready", {31'b0, bus.PREADY}, 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    xfer(1'b1, 8'h10, 32'hDEADBEEF);
    xfer(1'b0, 8'h10, '0);

    for (int i = 0; i < 32; i++) xfer(1'b1, AW'(i), 32'h1 << i);
    for (int i = 0; i < 32; i++) xfer(1'b0, AW'(i), '0);
    for (int i = 0; i < 32; i++) xfer(1'b1, AW'(i), ~(32'h1 << i));
    for (int i = 0; i < 32; i++) xfer(1'b0, AW'(i), '0);

    // Asynchronous reset pulse in the middle of a PREADY cycle.
    xfer(1'b1, 8'h03, 32'h5);
    xfer(1'b0, 8'h03, '0);
    #1 PRESETn = 1'b0;
    #1;
    check("async_reset_prdata", bus.PRDATA, 32'h0);
    check("async_reset_pready", {31'b0, bus.PREADY}, 32'h0);
    #1 PRESETn = 1'b1;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    bus_idle(1);
    xfer(1'b0, 8'h03, '0);
    xfer(1'b0, 8'h10, '0);

    // Setup phase skipped.
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 8'h20; bus.PWDATA = 32'hAAAA;
    hold_no_ready("no_setup", bus.PRDATA);
    bus_idle(1);
    xfer(1'b0, 8'h20, '0);

    // Address changes between setup and access.
    xfer(1'b1, 8'h04, 32'h0404_0404);
    xfer(1'b1, 8'h08, 32'h0808_0808);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'h04; bus.PWDATA = 32'hBAD0_0004;
    @(negedge PCLK);
    bus.PENABLE = 1'b1; bus.PADDR = 8'h08;
    hold_no_ready("addr_change", 32'h0);
    bus_idle(1);
    xfer(1'b0, 8'h04, '0);
    xfer(1'b0, 8'h08, '0);

    // Direction flips from read to write: PRDATA must keep the last read.
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h04;
    @(negedge PCLK);
    bus.PENABLE = 1'b1; bus.PWRITE = 1'b1;
    hold_no_ready("pwrite_change", 32'h0808_0808);
    bus_idle(1);

    // Write data changes between setup and access.
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'h05; bus.PWDATA = 32'h1111;
    @(negedge PCLK);
    bus.PENABLE = 1'b1; bus.PWDATA = 32'h2222;
    hold_no_ready("pwdata_change", 32'h0808_0808);
    bus_idle(1);
    xfer(1'b0, 8'h05, '0);

    xfer(1'b1, 8'h00, 32'h0000_A5A5);
    xfer(1'b1, 8'hFF, 32'hFFFF_5A5A);
    xfer(1'b0, 8'h00, '0);
    xfer(1'b0, 8'hFF, '0);

    for (int n = 0; n < 100; n++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = AW'($urandom_range(0, 2**AW - 1));
      r_data = $urandom();
      if (n >= 50) bus_idle(int'($urandom_range(0, 2)));
      xfer(r_wr, r_addr, r_data);
    end
    bus_idle(2);
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
